// File: rtl/pipe5_sub.sv
// pipe5_sub: pipelined subtractor recovering a = sum - b, borrow rippling through SLICE-bit stages.
// Optional borrow-event counter on uflow_cnt when PIPE5_SUB_UFLOW_CNT_EN is defined.
module pipe5_sub #(
    parameter int W     = 8,
    parameter int SLICE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   sum,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         wide,
    output logic         borrow
`ifdef PIPE5_SUB_UFLOW_CNT_EN
    ,
    output logic [7:0]   uflow_cnt
`endif
);

    localparam int STAGES = (W + SLICE) / SLICE;
    localparam int EW     = STAGES * SLICE;
    localparam int NR     = STAGES - 1;

    // Internal stages 0..NR-1 carry full operands plus the partially resolved result;
    // the final stage resolves the top slice straight into the output registers.
    logic              vld_q [NR];
    logic              vld_d [NR];
    logic [EW-1:0]     a_q   [NR];
    logic [EW-1:0]     a_d   [NR];
    logic [EW-1:0]     b_q   [NR];
    logic [EW-1:0]     b_d   [NR];
    logic [EW-1:0]     r_q   [NR];
    logic [EW-1:0]     r_d   [NR];
    logic              brw_q [NR];
    logic              brw_d [NR];

    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      diff_q, diff_d;
    logic              wide_q, wide_d;
    logic              borrow_q, borrow_d;

    logic              adv;
    logic [EW-1:0]     sum_ext;
    logic [EW-1:0]     b_ext;
    logic [EW-1:0]     r_fin;
    logic [SLICE:0]    t_c;

    // Returns {borrow_out, slice_difference}.
    function automatic logic [SLICE:0] slice_sub(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic             bin);
        slice_sub = {1'b0, x} - {1'b0, y} - {{SLICE{1'b0}}, bin};
    endfunction

    assign adv      = ~(out_valid_q & ~out_ready);
    assign in_ready = adv;
    assign sum_ext  = EW'(sum);
    assign b_ext    = EW'(b);

    always_comb begin
        t_c       = slice_sub(sum_ext[SLICE-1:0], b_ext[SLICE-1:0], 1'b0);
        vld_d[0]  = in_valid;
        a_d[0]    = sum_ext;
        b_d[0]    = b_ext;
        r_d[0]    = '0;
        r_d[0][SLICE-1:0] = t_c[SLICE-1:0];
        brw_d[0]  = t_c[SLICE];

        for (int k = 1; k < NR; k++) begin
            t_c      = slice_sub(a_q[k-1][k*SLICE +: SLICE], b_q[k-1][k*SLICE +: SLICE],
                                 brw_q[k-1]);
            vld_d[k] = vld_q[k-1];
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            r_d[k]   = r_q[k-1];
            r_d[k][k*SLICE +: SLICE] = t_c[SLICE-1:0];
            brw_d[k] = t_c[SLICE];
        end

        t_c   = slice_sub(a_q[NR-1][NR*SLICE +: SLICE], b_q[NR-1][NR*SLICE +: SLICE],
                          brw_q[NR-1]);
        r_fin = r_q[NR-1];
        r_fin[NR*SLICE +: SLICE] = t_c[SLICE-1:0];

        out_valid_d = vld_q[NR-1];
        diff_d      = r_fin[W-1:0];
        borrow_d    = r_fin[EW-1];
        wide_d      = r_fin[W] & ~r_fin[EW-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NR; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                r_q[k]   <= '0;
                brw_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            wide_q      <= 1'b0;
            borrow_q    <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NR; k++) begin
                vld_q[k] <= vld_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                r_q[k]   <= r_d[k];
                brw_q[k] <= brw_d[k];
            end
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            wide_q      <= wide_d;
            borrow_q    <= borrow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign wide      = wide_q;
    assign borrow    = borrow_q;

`ifdef PIPE5_SUB_UFLOW_CNT_EN
    logic [7:0] uflow_cnt_q;

    // Counted on the output handshake so a result held under stall counts once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uflow_cnt_q <= '0;
        end else if (out_valid_q && out_ready && borrow_q && (uflow_cnt_q != 8'hFF)) begin
            uflow_cnt_q <= uflow_cnt_q + 8'd1;
        end
    end

    assign uflow_cnt = uflow_cnt_q;
`endif

endmodule

// File: tb/tb_pipe5_sub.sv
// tb_pipe5_sub: directed table-driven bench for pipe5_sub with a scoreboard on output handshakes.
// Exercises the uflow_cnt counter when PIPE5_SUB_UFLOW_CNT_EN is defined.
module tb_pipe5_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] sum = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] diff;
    logic       wide;
    logic       borrow;
`ifdef PIPE5_SUB_UFLOW_CNT_EN
    logic [7:0] uflow_cnt;
`endif

    pipe5_sub dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .wide      (wide),
        .borrow    (borrow)
`ifdef PIPE5_SUB_UFLOW_CNT_EN
        ,
        .uflow_cnt (uflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] sum;
        logic [7:0] b;
        logic [7:0] diff;
        logic       wide;
        logic       borrow;
    } vec_t;

    typedef struct {
        logic [7:0] diff;
        logic       wide;
        logic       borrow;
        int         acc_cyc;
        bit         chk_lat;
    } exp_t;

    vec_t vecs [14];
    exp_t sbq [$];
    exp_t cur_exp;
    exp_t mon_e;
    bit   lat_chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Scoreboard: pop on output handshake, push on input accept.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got diff %0d, expected no output", diff);
                end else begin
                    mon_e = sbq.pop_front();
                    check("out_diff", 32'(diff), 32'(mon_e.diff));
                    check("out_wide", 32'(wide), 32'(mon_e.wide));
                    check("out_borrow", 32'(borrow), 32'(mon_e.borrow));
                    if (mon_e.chk_lat) check("latency", 32'(cyc - mon_e.acc_cyc), 32'd5);
                end
            end
            if (in_valid && in_ready) begin
                mon_e         = cur_exp;
                mon_e.acc_cyc = cyc;
                mon_e.chk_lat = lat_chk_en;
                sbq.push_back(mon_e);
            end
        end
    end

    task automatic set_item(input int idx);
        in_valid       = 1'b1;
        sum            = vecs[idx].sum;
        b              = vecs[idx].b;
        cur_exp.diff   = vecs[idx].diff;
        cur_exp.wide   = vecs[idx].wide;
        cur_exp.borrow = vecs[idx].borrow;
    endtask

    // Present one item and hold it until accepted; returns at posedge+2 with in_valid low.
    task automatic send(input int idx);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        set_item(idx);
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            n++;
            if (!acc && n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: item %0d not accepted after %0d cycles", idx, n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_pending", 32'(sbq.size()), 32'd0);
    endtask

    // Once out_valid rises, hold out_ready low for 3 cycles and check the output stays put.
    task automatic stall3();
        int n;
        logic [7:0] held_d;
        logic       held_w, held_b;
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("stall_wait_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        held_d = diff;
        held_w = wide;
        held_b = borrow;
        if (sbq.size() > 0) check("stall_head_diff", 32'(held_d), 32'(sbq[0].diff));
        else check("stall_head_present", 32'(sbq.size()), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_valid_held", 32'(out_valid), 32'd1);
            check("stall_diff_held", 32'(diff), 32'(held_d));
            check("stall_flags_held", 32'({wide, borrow}), 32'({held_w, held_b}));
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ov [18];
        int   stale;
        int   n;

        //           sum     b      diff    wide  borrow
        vecs[0]  = '{9'd16,  8'd9,   8'd7,   1'b0, 1'b0};
        vecs[1]  = '{9'd36,  8'd24,  8'd12,  1'b0, 1'b0};
        vecs[2]  = '{9'd32,  8'd1,   8'd31,  1'b0, 1'b0};
        vecs[3]  = '{9'd26,  8'd11,  8'd15,  1'b0, 1'b0};
        vecs[4]  = '{9'd7,   8'd4,   8'd3,   1'b0, 1'b0};
        vecs[5]  = '{9'd511, 8'd0,   8'd255, 1'b1, 1'b0};
        vecs[6]  = '{9'd0,   8'd255, 8'd1,   1'b0, 1'b1};
        vecs[7]  = '{9'd100, 8'd100, 8'd0,   1'b0, 1'b0};
        vecs[8]  = '{9'd256, 8'd1,   8'd255, 1'b0, 1'b0};
        vecs[9]  = '{9'd0,   8'd0,   8'd0,   1'b0, 1'b0};
        vecs[10] = '{9'd300, 8'd44,  8'd0,   1'b1, 1'b0};
        vecs[11] = '{9'd5,   8'd200, 8'd61,  1'b0, 1'b1};
        vecs[12] = '{9'd200, 8'd5,   8'd195, 1'b0, 1'b0};
        vecs[13] = '{9'd255, 8'd255, 8'd0,   1'b0, 1'b0};

        // Power-on reset
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_flags", 32'({wide, borrow}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;

        // Reset mid-stream: one item stalled at the output, three in flight
        out_ready = 1'b0;
        send(5); send(6); send(7); send(8);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_diff", 32'(diff), 32'd255);
        rst = 1'b0;
        sbq.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_flags", 32'({wide, borrow}), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_items", 32'(stale), 32'd0);
        @(posedge clk);
        #2;

        // Back-to-back stream with 5-cycle latency
        lat_chk_en = 1'b1;
        for (int i = 0; i < 5; i++) send(i);
        lat_chk_en = 1'b0;
        drain();

        // Edge values and remaining table entries
        for (int i = 5; i < 14; i++) send(i);
        drain();

        // Backpressure: six items, output stalled for 3 cycles
        fork
            begin
                for (int i = 8; i < 14; i++) send(i);
            end
            stall3();
        join
        drain();

        // Bubbles: in_valid alternates 1/0
        for (int j = 0; j < 18; j++) begin
            if (j < 12 && (j % 2) == 0) set_item(j / 2);
            else in_valid = 1'b0;
            @(negedge clk);
            ov[j] = out_valid;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        for (int j = 5; j < 17; j++)
            check($sformatf("bubble_valid_%0d", j), 32'(ov[j]),
                  32'((j <= 15) && (((j - 5) % 2) == 0)));
        drain();

`ifdef PIPE5_SUB_UFLOW_CNT_EN
        rst = 1'b0;
        #1;
        check("uflow_rst", 32'(uflow_cnt), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        fork
            send(6);
            stall3();
        join
        check("uflow_during_stall", 32'(uflow_cnt), 32'd0);
        @(posedge clk);
        #2;
        check("uflow_once", 32'(uflow_cnt), 32'd1);
        drain();
        check("uflow_once_after_drain", 32'(uflow_cnt), 32'd1);
        for (int i = 0; i < 300; i++) send(6);
        drain();
        check("uflow_saturated", 32'(uflow_cnt), 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
